// File: rtl/cache_pkg.sv
// Shared types and defaults for the CPU-side cache request master.
package cache_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // CPU request opcodes as carried on the command stream.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FLUSH = 2'b10,
        OP_RSVD  = 2'b11
    } cpu_op_e;

    // One response FIFO entry at the default data width.
    typedef struct packed {
        cpu_op_e                       op;
        logic [DEFAULT_DATA_WIDTH-1:0] rdata;
        logic                          error;
    } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always
// visible on rdata_o while empty_o is low. DEPTH must be a power of 2.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage write port.
    // NOTE: the data array has no reset; the pointers and count alone decide
    // which entries are valid, so clearing storage would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/cache_req_master.sv
// CPU-side initiator for the cache controller: takes commands on a
// valid/ready stream, runs one request at a time on the CPU bus, and
// returns a completion (or timeout/reserved error) through a response FIFO.
module cache_req_master
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_op,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] cpu_address,
    output logic                  cpu_read_enable,
    output logic                  cpu_write_enable,
    output logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic                  flush_request,
    input  logic [DATA_WIDTH-1:0] cpu_read_data,
    input  logic                  cpu_ready,
    output logic                  busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int FCNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Same layout as cache_pkg::rsp_t, sized by this instance's DATA_WIDTH.
    typedef struct packed {
        cpu_op_e               op;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  error;
    } rsp_entry_t;

    state_e                state_q, state_d;
    cpu_op_e               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  rsp_push;
    rsp_entry_t            rsp_in;
    rsp_entry_t            rsp_head;
    logic                  rsp_full;
    logic                  rsp_empty;
    logic [FCNT_W-1:0]     rsp_count;

    // Request state register: FSM state, latched command and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !rsp_full;

    // Next-state, command capture and response generation.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rsp_push = 1'b0;
        rsp_in   = '{op: OP_READ, rdata: '0, error: 1'b0};

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cpu_op_e'(cmd_op) == OP_RSVD) begin
                        rsp_push = 1'b1;
                        rsp_in   = '{op: OP_RSVD, rdata: '0, error: 1'b1};
                    end else begin
                        op_d    = cpu_op_e'(cmd_op);
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cpu_ready) begin
                    // Completion beats a coincident timeout.
                    rsp_push = 1'b1;
                    rsp_in   = '{op: op_q,
                                 rdata: (op_q == OP_READ) ? cpu_read_data : '0,
                                 error: 1'b0};
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_push = 1'b1;
                    rsp_in   = '{op: op_q, rdata: '0, error: 1'b1};
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .wdata_i (rsp_in),
        .pop_i   (rsp_ready),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    // Commands are only accepted with room in the FIFO, so it never overflows.
    assert property (@(posedge clk) disable iff (rst) rsp_count <= FCNT_W'(RSP_DEPTH));

    assign rsp_valid = !rsp_empty;
    assign rsp_op    = rsp_head.op;
    assign rsp_rdata = rsp_head.rdata;
    assign rsp_error = rsp_head.error;

    // Bus outputs come straight from state so the enable drops the cycle
    // after completion or reset.
    assign busy             = (state_q == ST_REQ);
    assign cpu_read_enable  = busy && (op_q == OP_READ);
    assign cpu_write_enable = busy && (op_q == OP_WRITE);
    assign flush_request    = busy && (op_q == OP_FLUSH);
    assign cpu_address      = addr_q;
    assign cpu_write_data   = wdata_q;

endmodule

// File: tb/tb_cache_req_master.sv
// Directed testbench for cache_req_master: bus timing, responses, FIFO
// back-pressure, mid-request reset, reserved ops and timeout priority.
`timescale 1ns/1ps
module tb_cache_req_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] cpu_address;
    logic        cpu_read_enable;
    logic        cpu_write_enable;
    logic [31:0] cpu_write_data;
    logic        flush_request;
    logic [31:0] cpu_read_data;
    logic        cpu_ready;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    cache_req_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .RSP_DEPTH      (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_op           (rsp_op),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .cpu_address      (cpu_address),
        .cpu_read_enable  (cpu_read_enable),
        .cpu_write_enable (cpu_write_enable),
        .cpu_write_data   (cpu_write_data),
        .flush_request    (flush_request),
        .cpu_read_data    (cpu_read_data),
        .cpu_ready        (cpu_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance; returns in the cycle after accept.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_accept: cmd_ready=%b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pop();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if ({cpu_read_enable, cpu_write_enable, flush_request, busy, rsp_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: rd/wr/fl/busy/rsp_valid=%b required 00000",
                     {cpu_read_enable, cpu_write_enable, flush_request, busy, rsp_valid});
        end
        tests_run++;
        if (cpu_address !== 32'h0 || cpu_write_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", cpu_address, cpu_write_data);
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        int hi = 0;
        issue(2'b00, 32'h0000_0040, 32'h0);
        if (cpu_read_enable === 1'b1) hi++;
        tests_run++;
        if (cpu_address !== 32'h0000_0040 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_issue: addr=%h busy=%b required 00000040/1", cpu_address, busy);
        end
        step();
        if (cpu_read_enable === 1'b1) hi++;
        step();
        if (cpu_read_enable === 1'b1) hi++;
        cpu_ready     = 1'b1;
        cpu_read_data = 32'hDEAD_BEEF;
        step();
        cpu_ready     = 1'b0;
        cpu_read_data = 32'h0;
        tests_run++;
        if (hi != 3 || cpu_read_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_enable_window: high %0d cycles, now %b; required 3 then 0", hi, cpu_read_enable);
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_op !== 2'b00 || rsp_rdata !== 32'hDEAD_BEEF || rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_rsp: v=%b op=%b d=%h e=%b required 1/00/deadbeef/0",
                     rsp_valid, rsp_op, rsp_rdata, rsp_error);
        end
        pop();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_pop: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_write();
        issue(2'b01, 32'h0000_0100, 32'h1234_5678);
        tests_run++;
        if (cpu_write_enable !== 1'b1 || cpu_read_enable !== 1'b0 || flush_request !== 1'b0 ||
            cpu_address !== 32'h100 || cpu_write_data !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL write_c1: wr=%b rd=%b fl=%b a=%h d=%h required 1/0/0/00000100/12345678",
                     cpu_write_enable, cpu_read_enable, flush_request, cpu_address, cpu_write_data);
        end
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        step();
        tests_run++;
        if (cpu_write_enable !== 1'b1 || cpu_address !== 32'h100 || cpu_write_data !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL write_hold: wr=%b a=%h d=%h required 1/00000100/12345678",
                     cpu_write_enable, cpu_address, cpu_write_data);
        end
        cpu_ready     = 1'b1;
        cpu_read_data = 32'hCAFE_F00D;
        step();
        cpu_ready = 1'b0;
        tests_run++;
        if (cpu_write_enable !== 1'b0 || rsp_valid !== 1'b1 || rsp_op !== 2'b01 ||
            rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_rsp: wr=%b v=%b op=%b d=%h e=%b required 0/1/01/0/0",
                     cpu_write_enable, rsp_valid, rsp_op, rsp_rdata, rsp_error);
        end
        pop();
    endtask

    task automatic test_flush_timeout();
        int hi = 0;
        issue(2'b10, 32'h0, 32'h0);
        while (flush_request === 1'b1 && hi < 100) begin
            hi++;
            step();
        end
        tests_run++;
        if (hi != 64) begin
            tests_failed++;
            $display("FAIL flush_window: flush high %0d cycles required 64", hi);
        end
        tests_run++;
        if (busy !== 1'b0 || rsp_valid !== 1'b1 || rsp_op !== 2'b10 || rsp_rdata !== 32'h0 || rsp_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_rsp: busy=%b v=%b op=%b d=%h e=%b required 0/1/10/0/1",
                     busy, rsp_valid, rsp_op, rsp_rdata, rsp_error);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, 32'h200 + 32'(4 * i), 32'h0);
            cpu_ready     = 1'b1;
            cpu_read_data = 32'(i + 1);
            step();
            cpu_ready = 1'b0;
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 32'h210;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (cmd_ready !== 1'b0 || cpu_read_enable !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_full_stall: cmd_ready=%b rd=%b required 0/0", cmd_ready, cpu_read_enable);
            end
            step();
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1) begin
            tests_failed++;
            $display("FAIL b2b_head: v=%b d=%h required 1/00000001", rsp_valid, rsp_rdata);
        end
        pop();
        issue(2'b00, 32'h210, 32'h0);
        tests_run++;
        if (cpu_read_enable !== 1'b1 || cpu_address !== 32'h210) begin
            tests_failed++;
            $display("FAIL b2b_fifth_issue: rd=%b a=%h required 1/00000210", cpu_read_enable, cpu_address);
        end
        cpu_ready     = 1'b1;
        cpu_read_data = 32'h5;
        step();
        cpu_ready = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_op !== 2'b00 || rsp_rdata !== 32'(i)) begin
                tests_failed++;
                $display("FAIL b2b_drain_%0d: v=%b op=%b d=%h required 1/00/%h", i, rsp_valid, rsp_op, rsp_rdata, 32'(i));
            end
            pop();
        end
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_empty: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_req();
        issue(2'b11, 32'h0, 32'h0);
        issue(2'b01, 32'h300, 32'hAAAA_5555);
        step();
        tests_run++;
        if (cpu_write_enable !== 1'b1 || rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre: wr=%b v=%b required 1/1", cpu_write_enable, rsp_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (cpu_write_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_post: wr=%b v=%b cmd_ready=%b busy=%b required 0/0/1/0",
                     cpu_write_enable, rsp_valid, cmd_ready, busy);
        end
        step();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_rsp: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reserved();
        cpu_ready = 1'b1;
        step();
        step();
        cpu_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_cpu_ready: v=%b busy=%b required 0/0", rsp_valid, busy);
        end
        issue(2'b11, 32'h400, 32'h1);
        tests_run++;
        if ({cpu_read_enable, cpu_write_enable, flush_request, busy} !== 4'b0) begin
            tests_failed++;
            $display("FAIL rsvd_no_bus: rd/wr/fl/busy=%b required 0000",
                     {cpu_read_enable, cpu_write_enable, flush_request, busy});
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_op !== 2'b11 || rsp_rdata !== 32'h0 || rsp_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL rsvd_rsp: v=%b op=%b d=%h e=%b required 1/11/0/1",
                     rsp_valid, rsp_op, rsp_rdata, rsp_error);
        end
        pop();
    endtask

    task automatic test_ready_at_timeout();
        issue(2'b00, 32'h500, 32'h0);
        repeat (63) step();
        tests_run++;
        if (cpu_read_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_last_cycle: rd=%b required 1", cpu_read_enable);
        end
        cpu_ready     = 1'b1;
        cpu_read_data = 32'hA5A5_A5A5;
        step();
        cpu_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_op !== 2'b00 || rsp_rdata !== 32'hA5A5_A5A5 || rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_ready_wins: v=%b op=%b d=%h e=%b required 1/00/a5a5a5a5/0",
                     rsp_valid, rsp_op, rsp_rdata, rsp_error);
        end
        pop();
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = 2'b00;
        cmd_addr      = 32'h0;
        cmd_wdata     = 32'h0;
        rsp_ready     = 1'b0;
        cpu_read_data = 32'h0;
        cpu_ready     = 1'b0;
        #1;
        test_reset();
        test_read();
        test_write();
        test_flush_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_reserved();
        test_ready_at_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
